s3_writeback_regfile: RTL and testbench

// - Write-back end of the S3 result interface: 32x32 register file consuming S3_Result/S3_WriteSelect/S3_WriteEnable.
// - Supplies two combinational operand reads to decode/S2; tracks in-flight destinations with per-register pending counters.
// - Raises stall on read-after-write hazards not yet retired through S3.

---
 rtl/s3_writeback_regfile_if.sv | 34 +++
 rtl/s3_writeback_regfile.sv | 112 +++++++++++
 tb/tb_s3_writeback_regfile.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/s3_writeback_regfile_if.sv
// Bundle between the S3 write-back / S2 issue / decode side (master) and the
// write-back register file (slave).
//   S3_Result, S3_WriteSelect, S3_WriteEnable : retiring write from S3
//   rd_sel_a/b -> rd_data_a/b                   : two combinational operand reads
//   issue_valid, issue_dest -> stall            : issue request and hazard stall
//   underflow_err                               : sticky retire-without-pending flag
interface s3_writeback_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [DATA_W-1:0] S3_Result;
    logic [ADDR_W-1:0] S3_WriteSelect;
    logic              S3_WriteEnable;
    logic [ADDR_W-1:0] rd_sel_a;
    logic [ADDR_W-1:0] rd_sel_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dest;
    logic              stall;
    logic              underflow_err;

    modport master (
        output S3_Result, S3_WriteSelect, S3_WriteEnable,
        output rd_sel_a, rd_sel_b, issue_valid, issue_dest,
        input  rd_data_a, rd_data_b, stall, underflow_err
    );

    modport slave (
        input  S3_Result, S3_WriteSelect, S3_WriteEnable,
        input  rd_sel_a, rd_sel_b, issue_valid, issue_dest,
        output rd_data_a, rd_data_b, stall, underflow_err
    );
endinterface

// File: rtl/s3_writeback_regfile.sv
// Write-back register file at the end of the S3 result path.
// 2**ADDR_W x DATA_W registers with two combinational read ports, per-register
// pending counters for in-flight destinations and a read-after-write stall.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : s3_writeback_regfile_if.slave (S3 write, operand reads, issue/stall,
//              sticky underflow_err)
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through
// forwarding from S3 to the read ports.
module s3_writeback_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned PEND_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    s3_writeback_regfile_if.slave  bus
);
    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [PEND_W-1:0] pend_q [NREGS];
    logic [PEND_W-1:0] pend_d [NREGS];
    logic              underflow_q;
    logic              underflow_d;

    logic              wr_live;
    logic              fwd_a;
    logic              fwd_b;
    logic              hazard_a;
    logic              hazard_b;
    logic              dest_full;
    logic              stall_c;
    logic              acc;

    // Register 0 is hard-wired; a write to it is not a commit.
    assign wr_live = bus.S3_WriteEnable && (bus.S3_WriteSelect != '0);

    // Operand reads (optionally forwarding the retiring S3 value).
    always_comb begin
        bus.rd_data_a = (bus.rd_sel_a == '0) ? '0 : regs_q[bus.rd_sel_a];
        bus.rd_data_b = (bus.rd_sel_b == '0) ? '0 : regs_q[bus.rd_sel_b];
        fwd_a = 1'b0;
        fwd_b = 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (bus.S3_WriteSelect == bus.rd_sel_a)) begin
            bus.rd_data_a = bus.S3_Result;
            // Only the last in-flight write clears the hazard.
            fwd_a = (pend_q[bus.rd_sel_a] == PEND_ONE);
        end
        if (wr_live && (bus.S3_WriteSelect == bus.rd_sel_b)) begin
            bus.rd_data_b = bus.S3_Result;
            fwd_b = (pend_q[bus.rd_sel_b] == PEND_ONE);
        end
`endif
    end

    // Hazard detection and issue acceptance.
    always_comb begin
        hazard_a  = (bus.rd_sel_a != '0) && (pend_q[bus.rd_sel_a] != '0) && !fwd_a;
        hazard_b  = (bus.rd_sel_b != '0) && (pend_q[bus.rd_sel_b] != '0) && !fwd_b;
        dest_full = (bus.issue_dest != '0) && (pend_q[bus.issue_dest] == PEND_MAX);
        stall_c   = bus.issue_valid && (hazard_a || hazard_b || dest_full);
        acc       = bus.issue_valid && !stall_c;
    end

    assign bus.stall         = stall_c;
    assign bus.underflow_err = underflow_q;

    // Pending counter next state; simultaneous issue and retire cancel out.
    always_comb begin
        underflow_d = underflow_q;
        pend_d[0]   = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            logic inc;
            logic dec;
            inc       = acc && (bus.issue_dest == ADDR_W'(r));
            dec       = bus.S3_WriteEnable && (bus.S3_WriteSelect == ADDR_W'(r));
            pend_d[r] = pend_q[r];
            if (inc && !dec) begin
                pend_d[r] = pend_q[r] + PEND_ONE;
            end else if (dec && !inc) begin
                if (pend_q[r] == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    pend_d[r] = pend_q[r] - PEND_ONE;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            underflow_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                pend_q[r] <= pend_d[r];
            end
            if (wr_live) begin
                regs_q[bus.S3_WriteSelect] <= bus.S3_Result;
            end
            underflow_q <= underflow_d;
        end
    end
endmodule

// File: tb/tb_s3_writeback_regfile.sv
module tb_s3_writeback_regfile;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int NREGS = 32;
    localparam int PMAX  = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    s3_writeback_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    s3_writeback_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PEND_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: plain arrays of values and in-flight counts.
    int unsigned m_regs [NREGS];
    int          m_pend [NREGS];
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input int sel);
        if (sel == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (bus.S3_WriteEnable && int'(bus.S3_WriteSelect) == sel) return bus.S3_Result;
`endif
        return m_regs[sel];
    endfunction

    function automatic bit m_hazard(input int sel);
        bit retiring_last;
        retiring_last = 1'b0;
`ifdef REGFILE_BYPASS_EN
        retiring_last = bus.S3_WriteEnable && int'(bus.S3_WriteSelect) == sel && m_pend[sel] == 1;
`endif
        return sel != 0 && m_pend[sel] != 0 && !retiring_last;
    endfunction

    function automatic bit m_stall();
        int d;
        d = int'(bus.issue_dest);
        return bus.issue_valid && (m_hazard(int'(bus.rd_sel_a)) || m_hazard(int'(bus.rd_sel_b)) ||
                                   (d != 0 && m_pend[d] == PMAX));
    endfunction

    task automatic m_clock(input bit stall_now);
        int  d;
        int  w;
        bit  acc;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = 0;
                m_pend[i] = 0;
            end
            m_err = 1'b0;
            return;
        end
        d   = int'(bus.issue_dest);
        w   = int'(bus.S3_WriteSelect);
        acc = bus.issue_valid && !stall_now && d != 0;
        if (bus.S3_WriteEnable && w != 0) begin
            m_regs[w] = bus.S3_Result;
            if (acc && d == w) begin
                // issue and retire of the same register cancel
            end else if (m_pend[w] == 0) begin
                m_err = 1'b1;
            end else begin
                m_pend[w]--;
            end
        end
        if (acc && !(bus.S3_WriteEnable && w == d)) m_pend[d]++;
    endtask

    // One clock: compare settled outputs at negedge, then advance the model.
    task automatic cycle();
        bit es;
        @(negedge clk);
        es = m_stall();
        check("rd_data_a", bus.rd_data_a, m_read(int'(bus.rd_sel_a)));
        check("rd_data_b", bus.rd_data_b, m_read(int'(bus.rd_sel_b)));
        check("stall", {31'b0, bus.stall}, {31'b0, es});
        check("underflow_err", {31'b0, bus.underflow_err}, {31'b0, m_err});
        @(posedge clk);
        m_clock(es);
        #1;
    endtask

    task automatic idle();
        rst                = 1'b0;
        bus.S3_Result      = '0;
        bus.S3_WriteSelect = '0;
        bus.S3_WriteEnable = 1'b0;
        bus.rd_sel_a       = '0;
        bus.rd_sel_b       = '0;
        bus.issue_valid    = 1'b0;
        bus.issue_dest     = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic s3_write(input int sel, input logic [31:0] val);
        bus.S3_WriteEnable = 1'b1;
        bus.S3_WriteSelect = ADDR_W'(sel);
        bus.S3_Result      = val;
    endtask

    task automatic issue(input int dest);
        bus.issue_valid = 1'b1;
        bus.issue_dest  = ADDR_W'(dest);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = 0;
            m_pend[i] = 0;
        end
        m_err = 1'b0;
        idle();
        do_reset();

        // After reset every register reads zero.
        for (int i = 0; i < NREGS; i += 2) begin
            idle();
            bus.rd_sel_a = ADDR_W'(i);
            bus.rd_sel_b = ADDR_W'(i + 1);
            cycle();
        end

        // Write r5, read it back; writes to r0 are dropped.
        idle(); s3_write(5, 32'hDEADBEEF); cycle();
        idle(); bus.rd_sel_a = 5; s3_write(0, 32'h1234); bus.rd_sel_b = 0; cycle();
        idle(); bus.rd_sel_a = 5; bus.rd_sel_b = 0;
        #1;
        check("r5_value", bus.rd_data_a, 32'hDEADBEEF);
        check("r0_zero", bus.rd_data_b, 32'h0);
        cycle();
        check("underflow_after_r5", {31'b0, bus.underflow_err}, 32'h1);
        do_reset();
        check("underflow_cleared", {31'b0, bus.underflow_err}, 32'h0);

        // RAW hazard on r7 and its release.
        idle(); issue(7); cycle();
        idle(); issue(8); bus.rd_sel_a = 7; #1;
        check("raw_stall_r7", {31'b0, bus.stall}, 32'h1);
        cycle();
        idle(); issue(8); bus.rd_sel_a = 7; s3_write(7, 32'hA5); #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_stall_r7", {31'b0, bus.stall}, 32'h0);
        check("bypass_data_r7", bus.rd_data_a, 32'hA5);
`else
        check("nobypass_stall_r7", {31'b0, bus.stall}, 32'h1);
`endif
        cycle();
        idle(); bus.rd_sel_a = 7; issue(10); #1;
        check("post_retire_r7", bus.rd_data_a, 32'hA5);
        check("post_retire_stall", {31'b0, bus.stall}, 32'h0);
        cycle();
        do_reset();

        // Pending counter saturation on r9.
        for (int k = 0; k < 3; k++) begin idle(); issue(9); cycle(); end
        idle(); issue(9); #1;
        check("r9_full_stall", {31'b0, bus.stall}, 32'h1);
        cycle();
        idle(); s3_write(9, 32'h99); cycle();
        idle(); issue(9); #1;
        check("r9_room_again", {31'b0, bus.stall}, 32'h0);
        cycle();
        do_reset();

        // Same-cycle issue and retire on r3 keeps count at 1.
        idle(); issue(3); cycle();
        idle(); issue(3); s3_write(3, 32'h333); cycle();
        idle(); issue(4); bus.rd_sel_b = 3; #1;
        check("r3_still_pending", {31'b0, bus.stall}, 32'h1);
        check("r3_updated", bus.rd_data_b, 32'h333);
        cycle();

        // Underflow on r12, sticky, cleared by reset mid-flight.
        idle(); s3_write(12, 32'hC); cycle();
        idle(); cycle();
        check("underflow_sticky", {31'b0, bus.underflow_err}, 32'h1);
        rst = 1'b1; cycle();
        idle(); issue(4); bus.rd_sel_a = 3; #1;
        check("reset_clears_pend", {31'b0, bus.stall}, 32'h0);
        check("reset_clears_err", {31'b0, bus.underflow_err}, 32'h0);
        idle();
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            bus.rd_sel_a = ADDR_W'($urandom_range(0, NREGS - 1));
            bus.rd_sel_b = ADDR_W'($urandom_range(0, NREGS - 1));
            bus.issue_valid = ($urandom_range(0, 9) < 6);
            bus.issue_dest  = ADDR_W'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 5) begin
                int pick;
                int start;
                pick  = $urandom_range(0, NREGS - 1);
                start = $urandom_range(0, NREGS - 1);
                if ($urandom_range(0, 19) != 0) begin
                    for (int j = 0; j < NREGS; j++) begin
                        if (m_pend[(start + j) % NREGS] != 0) begin
                            pick = (start + j) % NREGS;
                            break;
                        end
                    end
                end
                s3_write(pick, $urandom());
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
